// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional signed overflow output enabled by SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             bout,
  output logic             ovf
`else
  output logic             bout
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic             r_fin;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             w_d;
  logic             w_bo;

  assign w_d  = r_sa[0] ^ r_sb[0] ^ r_borrow;
  assign w_bo = (~r_sa[0] & r_sb[0])
              | (~r_sa[0] & r_borrow)
              | (r_sb[0] & r_borrow);

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic r_am;
  logic r_bm;
  logic r_ovf;

  assign ovf = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_am  <= 1'b0;
      r_bm  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_am <= a[WIDTH-1];
        r_bm <= b[WIDTH-1];
      end
      if (r_state == DONE && !r_fin) begin
        r_ovf <= (r_am != r_bm)
              && (r_res[WIDTH-1] != r_am);
      end
    end
  end
`endif

  // DONE spans two cycles: one to publish results, one with done high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_fin    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_sa     <= a;
            r_sb     <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_res    <= {w_d, r_res[WIDTH-1:1]};
          r_sa     <= r_sa >> 1;
          r_sb     <= r_sb >> 1;
          r_borrow <= w_bo;
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!r_fin) begin
            r_fin  <= 1'b1;
            r_done <= 1'b1;
            r_diff <= r_res;
            r_bout <= r_borrow;
          end else begin
            r_fin   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
